// File: rtl/serial_pkg.sv
// Shared constants and types for the serial frame engine and its sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_pkg;

  // Default width of the output and frequency patterns.
  localparam int DEF_DATA_BIT = 32;

  // Engine load mode: REPEAT reloads the presented patterns at frame end,
  // ONE_SHOT lets the engine return to idle after the current frame.
  localparam logic ONE_SHOT = 1'b0;
  localparam logic REPEAT   = 1'b1;

  // Selects which half of a pattern slot a host write lands in.
  localparam logic WR_SEL_OUT  = 1'b0;
  localparam logic WR_SEL_FREQ = 1'b1;

  // Sequencer control states.
  typedef enum logic [1:0] {
    C_IDLE  = 2'd0,
    C_START = 2'd1,
    C_RUN   = 2'd2,
    C_ABORT = 2'd3
  } seq_state_e;

endpackage

// File: rtl/pattern_slot_ram.sv
// Pattern slot store: SLOT_NUM entries of {output pattern, frequency pattern}.
// Latency: write lands at the clock edge; read is combinational from the registers.
// Backpressure: none; the caller gates i_wr_en (the sequencer blocks writes while busy).
//
// Ports:
//   clk, rst_n             clock, async active-low reset (clears every slot)
//   i_wr_en/_slot/_sel/_data  single write port; _sel picks output or frequency half
//   i_rd_slot              read index
//   o_rd_out, o_rd_freq    patterns held in slot i_rd_slot
module pattern_slot_ram
  import serial_pkg::*;
#(
  parameter int DATA_BIT = DEF_DATA_BIT,
  parameter int SLOT_NUM = 4,
  parameter int SLOT_AW  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_wr_en,
  input  logic [SLOT_AW-1:0]  i_wr_slot,
  input  logic                i_wr_sel,
  input  logic [DATA_BIT-1:0] i_wr_data,
  input  logic [SLOT_AW-1:0]  i_rd_slot,
  output logic [DATA_BIT-1:0] o_rd_out,
  output logic [DATA_BIT-1:0] o_rd_freq
);

  logic [DATA_BIT-1:0] out_q  [SLOT_NUM];
  logic [DATA_BIT-1:0] freq_q [SLOT_NUM];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SLOT_NUM; i++) begin
        out_q[i]  <= '0;
        freq_q[i] <= '0;
      end
    end else if (i_wr_en) begin
      if (i_wr_sel == WR_SEL_FREQ) begin
        freq_q[i_wr_slot] <= i_wr_data;
      end else begin
        out_q[i_wr_slot] <= i_wr_data;
      end
    end
  end

  assign o_rd_out  = out_q[i_rd_slot];
  assign o_rd_freq = freq_q[i_rd_slot];

endmodule

// File: rtl/serial_seq_ctrl.sv
// Sequencer stepping a serial_out engine through pattern slots 0..last, looping.
// Latency: all outputs registered; start one cycle after i_run, slot advance one cycle after i_done_tick.
// Backpressure: none; host writes while busy are dropped and flagged on o_wr_err.
//
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   i_wr_en/_slot/_sel/_data     host slot write (accepted only while idle)
//   i_last_slot, i_loop_cnt      sequence length and pass count (0 = forever), sampled at run
//   i_run, i_abort               start / abort pulses
//   i_done_tick                  engine frame-complete tick
//   o_start, o_stop, o_mode      engine controls (o_mode: 1 = REPEAT, 0 = ONE_SHOT)
//   o_output_pattern, o_freq_pattern  patterns the engine loads next
//   o_busy, o_slot, o_loops_left status; o_seq_done_tick on normal completion
//   o_wr_err                     one-cycle pulse when a write was dropped
module serial_seq_ctrl
  import serial_pkg::*;
#(
  parameter int DATA_BIT = DEF_DATA_BIT,
  parameter int SLOT_NUM = 4,
  parameter int SLOT_AW  = 2,
  parameter int LOOP_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_wr_en,
  input  logic [SLOT_AW-1:0]  i_wr_slot,
  input  logic                i_wr_sel,
  input  logic [DATA_BIT-1:0] i_wr_data,
  input  logic [SLOT_AW-1:0]  i_last_slot,
  input  logic [LOOP_W-1:0]   i_loop_cnt,
  input  logic                i_run,
  input  logic                i_abort,
  input  logic                i_done_tick,
  output logic                o_start,
  output logic                o_stop,
  output logic                o_mode,
  output logic [DATA_BIT-1:0] o_output_pattern,
  output logic [DATA_BIT-1:0] o_freq_pattern,
  output logic                o_busy,
  output logic [SLOT_AW-1:0]  o_slot,
  output logic [LOOP_W-1:0]   o_loops_left,
  output logic                o_seq_done_tick,
  output logic                o_wr_err
);

  localparam logic [SLOT_AW-1:0] SLOT_ONE = SLOT_AW'(1);
  localparam logic [LOOP_W-1:0]  LOOP_ONE = LOOP_W'(1);

  // Control state
  seq_state_e          state_q, state_d;
  logic [SLOT_AW-1:0]  cur_q, cur_d;      // slot the engine is playing
  logic [SLOT_AW-1:0]  pres_q, pres_d;    // slot on the pattern outputs
  logic [SLOT_AW-1:0]  last_q, last_d;
  logic [LOOP_W-1:0]   loop_q, loop_d;
  logic [LOOP_W-1:0]   left_q, left_d;
  logic                abort_cnt_q, abort_cnt_d;

  // Registered outputs
  logic                start_q, start_d;
  logic                stop_q, stop_d;
  logic                mode_q, mode_d;
  logic [DATA_BIT-1:0] out_pat_q, out_pat_d;
  logic [DATA_BIT-1:0] freq_pat_q, freq_pat_d;
  logic                busy_q, busy_d;
  logic                seq_done_q, seq_done_d;
  logic                wr_err_q, wr_err_d;

  // Slot store read side
  logic [SLOT_AW-1:0]  rd_slot;
  logic [DATA_BIT-1:0] rd_out;
  logic [DATA_BIT-1:0] rd_freq;
  logic                load_pat;

  // Candidate values for a non-final frame boundary
  logic [SLOT_AW-1:0]  cur_n;
  logic [SLOT_AW-1:0]  pres_n;
  logic [LOOP_W-1:0]   left_n;

  pattern_slot_ram #(
    .DATA_BIT (DATA_BIT),
    .SLOT_NUM (SLOT_NUM),
    .SLOT_AW  (SLOT_AW)
  ) u_slot_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (i_wr_en & ~busy_q),
    .i_wr_slot (i_wr_slot),
    .i_wr_sel  (i_wr_sel),
    .i_wr_data (i_wr_data),
    .i_rd_slot (rd_slot),
    .o_rd_out  (rd_out),
    .o_rd_freq (rd_freq)
  );

  // Wraps to slot 0 after the captured last slot.
  function automatic logic [SLOT_AW-1:0] next_slot(input logic [SLOT_AW-1:0] s);
    return (s == last_q) ? '0 : s + SLOT_ONE;
  endfunction

  // The frame on slot s with `left` passes remaining is the last one to play.
  function automatic logic is_final(input logic [SLOT_AW-1:0] s,
                                    input logic [LOOP_W-1:0]  left);
    return (s == last_q) && (loop_q != '0) && (left == LOOP_ONE);
  endfunction

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    pres_d      = pres_q;
    last_d      = last_q;
    loop_d      = loop_q;
    left_d      = left_q;
    abort_cnt_d = abort_cnt_q;
    start_d     = 1'b0;
    stop_d      = stop_q;
    mode_d      = mode_q;
    busy_d      = busy_q;
    seq_done_d  = 1'b0;
    wr_err_d    = i_wr_en & busy_q;
    rd_slot     = pres_q;
    load_pat    = 1'b0;

    cur_n  = next_slot(cur_q);
    pres_n = next_slot(cur_n);
    left_n = left_q;
    // A wrap back to slot 0 completes one pass; infinite runs keep the count at 0.
    if ((cur_n == '0) && (loop_q != '0)) begin
      left_n = left_q - LOOP_ONE;
    end

    unique case (state_q)
      C_IDLE: begin
        if (i_run) begin
          state_d  = C_START;
          last_d   = i_last_slot;
          loop_d   = i_loop_cnt;
          left_d   = i_loop_cnt;
          cur_d    = '0;
          pres_d   = '0;
          rd_slot  = '0;
          load_pat = 1'b1;
          start_d  = 1'b1;
          busy_d   = 1'b1;
          // The very first frame is also the final one for a single-slot, single-pass run.
          mode_d   = ((i_last_slot == '0) && (i_loop_cnt == LOOP_ONE)) ? ONE_SHOT : REPEAT;
        end
      end

      C_START: begin
        if (i_abort) begin
          state_d     = C_ABORT;
          stop_d      = 1'b1;
          mode_d      = ONE_SHOT;
          abort_cnt_d = 1'b0;
        end else begin
          // Present the follow-on slot so the engine's REPEAT reload picks it up.
          state_d  = C_RUN;
          pres_d   = next_slot('0);
          rd_slot  = next_slot('0);
          load_pat = 1'b1;
        end
      end

      C_RUN: begin
        if (i_abort) begin
          // Abort takes priority over a coincident done tick; cur stays put.
          state_d     = C_ABORT;
          stop_d      = 1'b1;
          mode_d      = ONE_SHOT;
          abort_cnt_d = 1'b0;
        end else if (i_done_tick) begin
          if (is_final(cur_q, left_q)) begin
            state_d    = C_IDLE;
            busy_d     = 1'b0;
            seq_done_d = 1'b1;
            left_d     = left_q - LOOP_ONE;
          end else begin
            cur_d    = cur_n;
            pres_d   = pres_n;
            left_d   = left_n;
            rd_slot  = pres_n;
            load_pat = 1'b1;
            mode_d   = is_final(cur_n, left_n) ? ONE_SHOT : REPEAT;
          end
        end
      end

      C_ABORT: begin
        // Stop is held for two cycles so an engine parked in its DONE state
        // also sees it; done ticks are ignored here.
        stop_d = 1'b1;
        mode_d = ONE_SHOT;
        if (abort_cnt_q) begin
          state_d     = C_IDLE;
          stop_d      = 1'b0;
          busy_d      = 1'b0;
          abort_cnt_d = 1'b0;
        end else begin
          abort_cnt_d = 1'b1;
        end
      end

      default: begin
        state_d = C_IDLE;
      end
    endcase

    out_pat_d  = load_pat ? rd_out  : out_pat_q;
    freq_pat_d = load_pat ? rd_freq : freq_pat_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= C_IDLE;
      cur_q       <= '0;
      pres_q      <= '0;
      last_q      <= '0;
      loop_q      <= '0;
      left_q      <= '0;
      abort_cnt_q <= 1'b0;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      mode_q      <= 1'b0;
      out_pat_q   <= '0;
      freq_pat_q  <= '0;
      busy_q      <= 1'b0;
      seq_done_q  <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      pres_q      <= pres_d;
      last_q      <= last_d;
      loop_q      <= loop_d;
      left_q      <= left_d;
      abort_cnt_q <= abort_cnt_d;
      start_q     <= start_d;
      stop_q      <= stop_d;
      mode_q      <= mode_d;
      out_pat_q   <= out_pat_d;
      freq_pat_q  <= freq_pat_d;
      busy_q      <= busy_d;
      seq_done_q  <= seq_done_d;
      wr_err_q    <= wr_err_d;
    end
  end

  assign o_start          = start_q;
  assign o_stop           = stop_q;
  assign o_mode           = mode_q;
  assign o_output_pattern = out_pat_q;
  assign o_freq_pattern   = freq_pat_q;
  assign o_busy           = busy_q;
  assign o_slot           = cur_q;
  assign o_loops_left     = left_q;
  assign o_seq_done_tick  = seq_done_q;
  assign o_wr_err         = wr_err_q;

endmodule
